// File: rtl/fnd_scan_ctrl.sv
// N-digit multiplexed common-anode 7-segment controller with a sequential
// double-dabble converter. Define FND_LZB_EN to enable leading-zero blanking.
module fnd_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int DATA_W     = 14,
  parameter int CLK_HZ     = 100_000_000,
  parameter int SCAN_HZ    = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [NUM_DIGITS-1:0] dot_mask,
  output logic                  busy,
  output logic                  ovf,
  output logic [NUM_DIGITS-1:0] fnd_digit,
  output logic [7:0]            fnd_data
);

  localparam int DIV   = CLK_HZ / SCAN_HZ;
  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int SR_W  = BCD_W + DATA_W;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int PS_W  = $clog2(DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);

  function automatic logic [63:0] max_display(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

  localparam logic [63:0] MAX_VAL = max_display(NUM_DIGITS);

  function automatic logic [7:0] glyph(input logic [3:0] v);
    case (v)
      4'd0:    glyph = 8'hC0;
      4'd1:    glyph = 8'hF9;
      4'd2:    glyph = 8'hA4;
      4'd3:    glyph = 8'hB0;
      4'd4:    glyph = 8'h99;
      4'd5:    glyph = 8'h92;
      4'd6:    glyph = 8'h82;
      4'd7:    glyph = 8'hF8;
      4'd8:    glyph = 8'h80;
      4'd9:    glyph = 8'h90;
      default: glyph = 8'hFF;
    endcase
  endfunction

  typedef enum logic {ST_IDLE, ST_CONV} state_t;

  state_t                state_q, state_d;
  logic [SR_W-1:0]       sr_q, sr_d, sr_adj, sr_step;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0] dot_pend_q, dot_pend_d;
  logic                  ovf_pend_q, ovf_pend_d;
  logic [BCD_W-1:0]      disp_bcd_q, disp_bcd_d;
  logic [NUM_DIGITS-1:0] disp_dot_q, disp_dot_d;
  logic                  disp_ovf_q, disp_ovf_d;
  logic                  accept, last_iter, commit;

  logic [PS_W-1:0]       presc_q, presc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_DIGITS-1:0] digit_q, digit_d;
  logic [7:0]            seg_q, seg_d, seg_cur;
  logic [3:0]            nib_cur;
  logic [NUM_DIGITS-1:0] shown;
  logic                  tick;

  assign accept    = load && (state_q == ST_IDLE);
  assign last_iter = (state_q == ST_CONV) && (cnt_q == CNT_W'(DATA_W - 1));

  // Add-3 correction on every BCD nibble, then a single left shift.
  assign sr_adj[DATA_W-1:0] = sr_q[DATA_W-1:0];
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
    logic [3:0] nib;
    assign nib = sr_q[DATA_W + 4*gi +: 4];
    assign sr_adj[DATA_W + 4*gi +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
  end
  assign sr_step = sr_adj << 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (load)      state_d = ST_CONV;
      ST_CONV: if (last_iter) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q == ST_CONV);
    commit = last_iter;
  end

  always_comb begin
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    dot_pend_d = dot_pend_q;
    ovf_pend_d = ovf_pend_q;
    disp_bcd_d = disp_bcd_q;
    disp_dot_d = disp_dot_q;
    disp_ovf_d = disp_ovf_q;
    if (accept) begin
      sr_d       = {{BCD_W{1'b0}}, in_data};
      cnt_d      = '0;
      dot_pend_d = dot_mask;
      ovf_pend_d = (64'(in_data) > MAX_VAL);
    end else if (busy) begin
      sr_d  = sr_step;
      cnt_d = cnt_q + CNT_W'(1);
      if (commit) begin
        disp_bcd_d = sr_step[SR_W-1 -: BCD_W];
        disp_dot_d = dot_pend_q;
        disp_ovf_d = ovf_pend_q;
      end
    end
  end

`ifdef FND_LZB_EN
  // A digit is shown once any digit at or above it is nonzero; digit 0 always.
  always_comb begin
    logic seen;
    seen  = 1'b0;
    shown = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      seen     = seen | (disp_bcd_q[4*i +: 4] != 4'd0);
      shown[i] = seen | (i == 0);
    end
  end
`else
  assign shown = '1;
`endif

  assign tick    = (presc_q == PS_W'(DIV - 1));
  assign nib_cur = disp_bcd_q[4*idx_q +: 4];

  always_comb begin
    if (disp_ovf_q) begin
      seg_cur = 8'hBF;
    end else begin
      seg_cur = shown[idx_q] ? glyph(nib_cur) : 8'hFF;
      if (disp_dot_q[idx_q]) seg_cur[7] = 1'b0;
    end
  end

  always_comb begin
    presc_d = presc_q + PS_W'(1);
    idx_d   = idx_q;
    digit_d = digit_q;
    seg_d   = seg_q;
    if (tick) begin
      presc_d        = '0;
      idx_d          = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
      digit_d        = '1;
      digit_d[idx_q] = 1'b0;
      seg_d          = seg_cur;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q       <= '0;
      cnt_q      <= '0;
      dot_pend_q <= '0;
      ovf_pend_q <= 1'b0;
      disp_bcd_q <= '0;
      disp_dot_q <= '0;
      disp_ovf_q <= 1'b0;
      presc_q    <= '0;
      idx_q      <= '0;
      digit_q    <= '1;
      seg_q      <= 8'hFF;
    end else begin
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      dot_pend_q <= dot_pend_d;
      ovf_pend_q <= ovf_pend_d;
      disp_bcd_q <= disp_bcd_d;
      disp_dot_q <= disp_dot_d;
      disp_ovf_q <= disp_ovf_d;
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      digit_q    <= digit_d;
      seg_q      <= seg_d;
    end
  end

  assign ovf       = disp_ovf_q;
  assign fnd_digit = digit_q;
  assign fnd_data  = seg_q;

endmodule
